// File: rtl/serial_add_sub.sv
// ============================================================================
// Module   : serial_add_sub
// Purpose  : Add/subtract unit that works through CHUNK bits per clock, LSB first,
//            using one CHUNK-wide adder slice. Reports carry/borrow and signed overflow.
// Options  : SERIAL_ADD_SUB_SATURATE_EN enables unsigned saturation of o_result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_sub #(
  parameter int BITS  = 8,
  parameter int CHUNK = 2
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_subtract,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [BITS-1:0] o_result,
  output logic            o_carry,
  output logic            o_overflow
);

  localparam int K  = BITS / CHUNK;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(K - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  generate
    if (BITS < 1 || CHUNK < 1 || (BITS % CHUNK) != 0) begin : g_param_check
      $error("serial_add_sub: BITS must be >= 1 and a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]      r_state;
  logic [BITS-1:0] r_a;
  logic [BITS-1:0] r_b;
  logic [BITS-1:0] r_res;
  logic            r_sub;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic [BITS-1:0] r_result;
  logic            r_carry_flag;
  logic            r_overflow;

  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_sum;
  logic             w_cin_msb;
  logic             w_flag_c;
  logic [BITS-1:0]  w_res_next;
  logic [BITS-1:0]  w_a_next;
  logic [BITS-1:0]  w_b_next;
  logic [BITS-1:0]  w_result_final;

  assign w_b_chunk = r_b[CHUNK-1:0] ^ {CHUNK{r_sub}};
  assign w_sum     = {1'b0, r_a[CHUNK-1:0]} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
  // Carry into the slice MSB recovered from the MSB sum bit; reduces to r_carry when CHUNK = 1.
  assign w_cin_msb = r_a[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1];
  assign w_flag_c  = w_sum[CHUNK] ^ r_sub;

  generate
    if (K == 1) begin : g_single
      assign w_res_next = w_sum[CHUNK-1:0];
      assign w_a_next   = r_a;
      assign w_b_next   = r_b;
    end else begin : g_multi
      assign w_res_next = {w_sum[CHUNK-1:0], r_res[BITS-1:CHUNK]};
      assign w_a_next   = {{CHUNK{1'b0}}, r_a[BITS-1:CHUNK]};
      assign w_b_next   = {{CHUNK{1'b0}}, r_b[BITS-1:CHUNK]};
    end
  endgenerate

`ifdef SERIAL_ADD_SUB_SATURATE_EN
  always_comb begin
    w_result_final = w_res_next;
    if (w_flag_c) begin
      w_result_final = r_sub ? '0 : '1;
    end
  end
`else
  assign w_result_final = w_res_next;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= c_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_sub        <= 1'b0;
      r_carry      <= 1'b0;
      r_cnt        <= '0;
      r_result     <= '0;
      r_carry_flag <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_sub   <= i_subtract;
            r_carry <= i_subtract;
            r_cnt   <= '0;
            r_state <= c_RUN;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_RUN: begin
          r_a     <= w_a_next;
          r_b     <= w_b_next;
          r_res   <= w_res_next;
          r_carry <= w_sum[CHUNK];
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_state      <= c_DONE;
            r_result     <= w_result_final;
            r_carry_flag <= w_flag_c;
            r_overflow   <= w_cin_msb ^ w_sum[CHUNK];
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state == c_RUN);
  assign o_done     = (r_state == c_DONE);
  assign o_result   = r_result;
  assign o_carry    = r_carry_flag;
  assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub.sv
// ============================================================================
// Module   : tb_serial_add_sub
// Purpose  : Bench for serial_add_sub with three instances: 8/2, 4/1 and 8/8 (bits/chunk).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_sub;

  typedef struct packed {
    logic [1:0] id;
    logic       c;
    logic       v;
    logic [7:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] st = '0;
  logic [2:0] sb = '0;
  logic [7:0] ia [3];
  logic [7:0] ib [3];
  logic [2:0] bz, dn, cy, ov;
  logic [7:0] rs0, rs2;
  logic [3:0] rs1;

  int   total  = 0;
  int   passed = 0;
  exp_t pq[$];
  exp_t hold [3];

  serial_add_sub #(.BITS(8), .CHUNK(2)) u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_start(st[0]), .i_subtract(sb[0]),
    .i_a(ia[0]), .i_b(ib[0]), .o_busy(bz[0]), .o_done(dn[0]),
    .o_result(rs0), .o_carry(cy[0]), .o_overflow(ov[0]));

  serial_add_sub #(.BITS(4), .CHUNK(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_start(st[1]), .i_subtract(sb[1]),
    .i_a(ia[1][3:0]), .i_b(ib[1][3:0]), .o_busy(bz[1]), .o_done(dn[1]),
    .o_result(rs1), .o_carry(cy[1]), .o_overflow(ov[1]));

  serial_add_sub #(.BITS(8), .CHUNK(8)) u_dut2 (
    .i_clock(clk), .i_reset(rst), .i_start(st[2]), .i_subtract(sb[2]),
    .i_a(ia[2]), .i_b(ib[2]), .o_busy(bz[2]), .o_done(dn[2]),
    .o_result(rs2), .o_carry(cy[2]), .o_overflow(ov[2]));

  function automatic logic [7:0] get_res(input int d);
    case (d)
      0:       return rs0;
      1:       return {4'b0000, rs1};
      default: return rs2;
    endcase
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int id, input logic sub, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int bits, ua, ub, mask, full, sa, sbv, s;
    bits = (id == 1) ? 4 : 8;
    mask = (1 << bits) - 1;
    ua   = int'(a) & mask;
    ub   = int'(b) & mask;
    full = sub ? (ua - ub) : (ua + ub);
    e.r  = 8'(full & mask);
    e.c  = sub ? (ua < ub) : (((full >> bits) & 1) != 0);
    sa   = (ua >= (1 << (bits - 1))) ? ua - (1 << bits) : ua;
    sbv  = (ub >= (1 << (bits - 1))) ? ub - (1 << bits) : ub;
    s    = sub ? (sa - sbv) : (sa + sbv);
    e.v  = (s > (mask >> 1)) || (s < -(1 << (bits - 1)));
`ifdef SERIAL_ADD_SUB_SATURATE_EN
    if (e.c) e.r = sub ? 8'h00 : 8'(mask);
`endif
    e.id = 2'(id);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  // Every cycle: outputs must hold the last completed result; a done pulse retires the oldest request.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) hold[d] = '0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (dn[d]) begin
          if (pq.size() != 0 && pq[0].id == 2'(d)) hold[d] = pq.pop_front();
          else chk("spurious_done", int'(dn[d]), 0);
        end
        chk("result",    int'(get_res(d)), int'(hold[d].r));
        chk("carry",     int'(cy[d]),      int'(hold[d].c));
        chk("overflow",  int'(ov[d]),      int'(hold[d].v));
        chk("busy_done", int'(bz[d] & dn[d]), 0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy",   int'(bz[d]), 0);
      chk("rst_done",   int'(dn[d]), 0);
      chk("rst_result", int'(get_res(d)), 0);
      chk("rst_carry",  int'(cy[d]), 0);
      chk("rst_ovf",    int'(ov[d]), 0);
    end
    pq.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Issue one request; returns 2 time units into the done cycle.
  task automatic op(input int id, input logic sub, input logic [7:0] a, input logic [7:0] b, input bit keep_start);
    int k, edges;
    k = (id == 2) ? 1 : 4;
    st[id] = 1'b1; sb[id] = sub; ia[id] = a; ib[id] = b;
    @(posedge clk);
    pq.push_back(model(id, sub, a, b));
    #2;
    if (keep_start) begin
      ia[id] = 8'($urandom); ib[id] = 8'($urandom); sb[id] = ~sub;
    end else begin
      st[id] = 1'b0;
    end
    edges = 0;
    while (!dn[id] && edges < 40) begin
      chk("busy_during_run", int'(bz[id]), 1);
      @(posedge clk);
      #2;
      edges++;
    end
    st[id] = 1'b0;
    chk("latency", edges, k);
  endtask

  task automatic lit(input int id, input int r, input int c, input int v);
    chk("lit_result",   int'(get_res(id)), r);
    chk("lit_carry",    int'(cy[id]), c);
    chk("lit_overflow", int'(ov[id]), v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin ia[d] = '0; ib[d] = '0; end
    do_reset();

    // Reset mid-operation: asynchronous clear, no done pulse.
    op(0, 1'b0, 8'h12, 8'h34, 1'b0);
    lit(0, 8'h46, 0, 0);
    idle(1);
    st[0] = 1'b1; sb[0] = 1'b0; ia[0] = 8'hF0; ib[0] = 8'h0F;
    @(posedge clk); #2;
    st[0] = 1'b0;
    @(posedge clk); #2;
    chk("busy_before_abort", int'(bz[0]), 1);
    do_reset();
    idle(6);

    // Directed cases
`ifdef SERIAL_ADD_SUB_SATURATE_EN
    op(0, 1'b1, 8'd5, 8'd9, 1'b0);     lit(0, 8'h00, 1, 0);
    op(0, 1'b0, 8'hFF, 8'h01, 1'b0);   lit(0, 8'hFF, 1, 0);
    op(0, 1'b0, 8'hFF, 8'hFF, 1'b0);   lit(0, 8'hFF, 1, 0);
    op(2, 1'b0, 8'd200, 8'd100, 1'b0); lit(2, 8'hFF, 1, 0);
`else
    op(0, 1'b1, 8'd5, 8'd9, 1'b0);     lit(0, 8'hFC, 1, 0);
    op(0, 1'b0, 8'hFF, 8'h01, 1'b0);   lit(0, 8'h00, 1, 0);
    op(0, 1'b0, 8'hFF, 8'hFF, 1'b0);   lit(0, 8'hFE, 1, 0);
    op(2, 1'b0, 8'd200, 8'd100, 1'b0); lit(2, 8'd44, 1, 0);
`endif
    op(0, 1'b1, 8'h80, 8'h01, 1'b0);   lit(0, 8'h7F, 0, 1);
    op(0, 1'b0, 8'h7F, 8'h01, 1'b0);   lit(0, 8'h80, 0, 1);
    op(0, 1'b1, 8'd9, 8'd5, 1'b0);     lit(0, 8'h04, 0, 0);
    op(0, 1'b1, 8'h00, 8'h00, 1'b0);   lit(0, 8'h00, 0, 0);
    idle(2);

    // Handshake: start held through RUN is ignored; start during done is accepted.
    op(0, 1'b0, 8'h11, 8'h22, 1'b1);   lit(0, 8'h33, 0, 0);
    op(0, 1'b1, 8'h40, 8'h50, 1'b0);   lit(0, 8'hF0 & ((model(0, 1'b1, 8'h40, 8'h50).c) ? 8'hFF : 8'hFF), 1, 0);
    idle(5);
    lit(0, int'(model(0, 1'b1, 8'h40, 8'h50).r), 1, 0);

    // Exhaustive 4-bit, chunk 1
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          op(1, 1'(s), 8'(x), 8'(y), 1'b0);
    idle(2);

    // Randomized traffic on the 8-bit instances
    for (int i = 0; i < 240; i++) begin
      op((i % 4 == 3) ? 2 : 0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
         ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    chk("queue_drained", pq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Multi-cycle, parametrised add/subtract unit that processes operands CHUNK bits per clock, LSB-first, through a single CHUNK-wide adder slice.
Successor to the combinational Subtractor:
- adds a mode input (add or subtract)
- adds signed-overflow reporting
- adds a start/busy/done handshake
Used where BITS is wide and area matters more than latency.

Parameters:
BITS, 8, operand and result width; must be ≥ 1.
CHUNK, 2, bits processed per cycle; BITS % CHUNK must be 0, otherwise elaboration error ($error in generate).

Ports:
i_clock  input  1  rising-edge clock
i_reset  input  1  asynchronous, active-high reset
i_start  input  1  request; accepted only when o_busy = 0
i_subtract  input  1  mode sampled with i_start: 0 = A+B, 1 = A-B
i_a  input  BITS  operand A / minuend, sampled with i_start
i_b  input  BITS  operand B / subtrahend, sampled with i_start
o_busy  output  1  operation in progress
o_done  output  1  one-cycle completion pulse
o_result  output  BITS  sum or difference
o_carry  output  1  add: carry out; subtract: borrow (1 when A < B unsigned)
o_overflow  output  1  two's-complement signed overflow

Behaviour:
Reset:
- Asynchronous; state goes to IDLE.
- All outputs 0: o_busy, o_done, o_result, o_carry, o_overflow.
- Internal shift registers, counter and carry are cleared.
- Reset mid-operation aborts the operation; no o_done pulse is produced.

States: IDLE, RUN, DONE.
- Let K = BITS/CHUNK.
- IDLE or DONE, with i_start = 1 at an edge:
  - latch i_a, i_b and i_subtract into shift registers
  - chunk counter = 0
  - carry register = i_subtract
  - go to RUN
- IDLE or DONE, i_start = 0: DONE returns to IDLE; IDLE stays in IDLE.
- RUN, each edge:
  - Compute low CHUNK bits of A + (B XOR {CHUNK{subtract}}) + carry.
  - Shift the result chunk into the result shift register from the MSB side.
  - Shift A and B right by CHUNK; update carry; increment counter.
  - On the edge processing chunk K-1, go to DONE.
- i_start while in RUN is ignored; no queuing.

Outputs:
- o_busy = (state == RUN).
- o_done = (state == DONE), high for exactly one cycle.
- o_done rises on the K-th edge after the accepting edge; o_busy falls on that same edge.
- Back-to-back operation: i_start asserted while o_done = 1 is accepted. Throughput is one result per K+1 cycles.
- o_result, o_carry and o_overflow update only on the completing edge. They hold until the next completion or reset and never show partial results.

Flags:
- o_carry:
  - add: final carry
  - subtract: NOT final carry, i.e. the borrow
- Add: {o_carry, o_result} equals the unsigned A+B in BITS+1 bits.
- Subtract: {o_carry, o_result}, read as a signed BITS+1 value, equals A-B for unsigned A and B.
- o_overflow = carry into MSB XOR carry out of MSB. This is computed inside the last chunk; when CHUNK = 1 it is the carry register entering the last cycle.

Boundaries:
- BITS = CHUNK gives K = 1: a single RUN cycle, and done arrives 1 edge after accept.
- 0 - 0: result 0, borrow 0.
- Max + max in add mode: result {1'b1, all ones << 1}, i.e. carry 1.

Optional Feature:
Macro: SERIAL_ADD_SUB_SATURATE_EN.
- Defined: unsigned saturation at completion.
  - add with carry out: o_result = all ones
  - subtract with borrow: o_result = 0
  - o_carry and o_overflow still report the raw (unsaturated) flags
- Undefined: o_result wraps modulo 2^BITS.
- Timing is identical in both builds.

Test Plan:
1. BITS=8, CHUNK=2. Reset asserted mid-RUN: all outputs 0 immediately (asynchronous), no o_done pulse. Then A=5, B=9, subtract -> o_done exactly 4 edges after accept, o_result=0xFC, o_carry=1, o_overflow=0, o_busy high for those 4 cycles.
2. BITS=8, CHUNK=2, signed-overflow cases:
   - subtract 0x80-0x01 -> 0x7F, carry 0, overflow 1
   - add 0x7F+0x01 -> 0x80, carry 0, overflow 1
   - add 0xFF+0x01 -> 0x00, carry 1, overflow 0
3. BITS=4, CHUNK=1, exhaustive 16x16 pairs in both modes:
   - add: {o_carry, o_result} == x+y
   - subtract: signed 5-bit {o_carry, o_result} == x-y
   - latency 4 edges for every pair
4. Handshake, BITS=8, CHUNK=2:
   - i_start held high during RUN with different operands -> ignored
   - i_start during the o_done cycle -> accepted; second result correct after a further 4 edges
   - outputs hold between operations
5. BITS=8, CHUNK=8 (K=1): add 200+100 -> o_result=44, o_carry=1, done 1 edge after accept.
6. With SERIAL_ADD_SUB_SATURATE_EN defined:
   - add 0xFF+0x01 -> 0xFF, carry 1
   - subtract 5-9 -> 0x00, carry 1
   - subtract 9-5 -> 0x04, carry 0
